pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/pipe_ctrl_pkg.sv | 66 ++++++
 rtl/pipe_ctrl_unit_decoder.sv | 87 ++++++++
 rtl/pipe_ctrl_unit.sv | 199 +++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the in-order pipeline control slice: opcodes, field
// encodings and the bit layout of the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam int CTRL_W   = 16;
    localparam int MD_CNT_W = 6;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_IMM = 2'b10,
        RES_PC4 = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_JAL  = 2'b01,
        JMP_JALR = 2'b10
    } jump_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } alu_op_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Bundle layout, LSB first; bits from CTRL_USED upward are always zero.
    localparam int B_REGWRITE  = 0;
    localparam int B_RESULTSRC = 1;
    localparam int B_MEMREAD   = 3;
    localparam int B_MEMWRITE  = 4;
    localparam int B_ALUOP     = 5;
    localparam int B_ALUSRC    = 7;
    localparam int B_ALUASRC   = 8;
    localparam int B_BRANCH    = 9;
    localparam int B_JUMP      = 10;
    localparam int B_MULDIV    = 12;
    localparam int CTRL_USED   = 13;

    function automatic logic [4:0] rs1_field(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_field(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_field(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Pure combinational RV32I(+M) main decoder: instruction word to control
// bundle, illegal-opcode flag and register-source usage.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
#(
    parameter int EN_MULDIV = 1,
    parameter int CTRL_W    = pipe_ctrl_pkg::CTRL_W
) (
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic              rs1_used,
    output logic              rs2_used
);

    logic unused_funct3;
    assign unused_funct3 = ^instr[14:12];

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                ctrl[B_REGWRITE]    = 1'b1;
                ctrl[B_ALUOP +: 2]  = ALUOP_FUNCT;
                if (EN_MULDIV != 0 && instr[31:25] == FUNCT7_MULDIV) begin
                    ctrl[B_MULDIV] = 1'b1;
                end
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl[B_REGWRITE]    = 1'b1;
                ctrl[B_ALUSRC]      = 1'b1;
                ctrl[B_ALUOP +: 2]  = ALUOP_FUNCT;
                rs1_used = 1'b1;
            end
            OPC_LOAD: begin
                ctrl[B_REGWRITE]       = 1'b1;
                ctrl[B_RESULTSRC +: 2] = RES_MEM;
                ctrl[B_MEMREAD]        = 1'b1;
                ctrl[B_ALUSRC]         = 1'b1;
                rs1_used = 1'b1;
            end
            OPC_STORE: begin
                ctrl[B_MEMWRITE] = 1'b1;
                ctrl[B_ALUSRC]   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl[B_BRANCH]     = 1'b1;
                ctrl[B_ALUOP +: 2] = ALUOP_BRANCH;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_JAL: begin
                ctrl[B_REGWRITE]       = 1'b1;
                ctrl[B_RESULTSRC +: 2] = RES_PC4;
                ctrl[B_JUMP +: 2]      = JMP_JAL;
            end
            OPC_JALR: begin
                ctrl[B_REGWRITE]       = 1'b1;
                ctrl[B_RESULTSRC +: 2] = RES_PC4;
                ctrl[B_ALUSRC]         = 1'b1;
                ctrl[B_JUMP +: 2]      = JMP_JALR;
                rs1_used = 1'b1;
            end
            OPC_LUI: begin
                ctrl[B_REGWRITE]       = 1'b1;
                ctrl[B_RESULTSRC +: 2] = RES_IMM;
                ctrl[B_ALUSRC]         = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl[B_REGWRITE] = 1'b1;
                ctrl[B_ALUSRC]   = 1'b1;
                ctrl[B_ALUASRC]  = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// EX/MEM/WB control pipeline: stage registers, load-use and M-extension
// interlocks, branch squash and operand forwarding selects.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int EN_MULDIV     = 1,
    parameter int MULDIV_CYCLES = 8,
    parameter int CTRL_W        = pipe_ctrl_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    output logic              id_ready,
    input  logic              ex_redirect,
    input  logic              stall_ext,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [4:0]        ex_rd,
    output logic [4:0]        mem_rd,
    output logic [4:0]        wb_rd,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              illegal
);

    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MULDIV_CYCLES - 1);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              dec_rs1_used;
    logic              dec_rs2_used;

    ctrl_decoder #(
        .EN_MULDIV (EN_MULDIV),
        .CTRL_W    (CTRL_W)
    ) u_decoder (
        .instr    (id_instr),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;

    assign id_rs1 = rs1_field(id_instr);
    assign id_rs2 = rs2_field(id_instr);
    assign id_rd  = rd_field(id_instr);

    logic              ex_valid_q,  ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
    logic [4:0]        ex_rd_q,     ex_rd_d;
    logic [4:0]        ex_rs1_q,    ex_rs1_d;
    logic [4:0]        ex_rs2_q,    ex_rs2_d;
    logic              ex_ill_q,    ex_ill_d;
    logic              mem_valid_q, mem_valid_d;
    logic [CTRL_W-1:0] mem_ctrl_q,  mem_ctrl_d;
    logic [4:0]        mem_rd_q,    mem_rd_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [CTRL_W-1:0] wb_ctrl_q,   wb_ctrl_d;
    logic [4:0]        wb_rd_q,     wb_rd_d;
    logic [MD_CNT_W-1:0] md_cnt_q,  md_cnt_d;

    logic load_use;
    logic md_hold;
    logic id_ready_c;

    // Unused source fields are staged as x0 so they can never match a producer.
    always_comb begin
        load_use = id_valid && ex_valid_q && ex_ctrl_q[B_MEMREAD] && (ex_rd_q != '0)
                   && ((dec_rs1_used && (id_rs1 == ex_rd_q))
                    || (dec_rs2_used && (id_rs2 == ex_rd_q)));
        md_hold  = ex_valid_q && ex_ctrl_q[B_MULDIV] && (md_cnt_q != '0);

        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_rd_d     = ex_rd_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_ill_d    = ex_ill_q;
        mem_valid_d = mem_valid_q;
        mem_ctrl_d  = mem_ctrl_q;
        mem_rd_d    = mem_rd_q;
        wb_valid_d  = wb_valid_q;
        wb_ctrl_d   = wb_ctrl_q;
        wb_rd_d     = wb_rd_q;
        md_cnt_d    = md_cnt_q;
        id_ready_c  = 1'b0;

        if (!stall_ext) begin
            wb_valid_d = mem_valid_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_rd_d    = mem_rd_q;
            if (md_hold) begin
                mem_valid_d = 1'b0;
                mem_ctrl_d  = '0;
                mem_rd_d    = '0;
                md_cnt_d    = md_cnt_q - 1'b1;
            end else begin
                mem_valid_d = ex_valid_q;
                mem_ctrl_d  = ex_ctrl_q;
                mem_rd_d    = ex_rd_q;
                id_ready_c  = ex_redirect || !load_use;
                if (id_valid && !ex_redirect && !load_use) begin
                    ex_valid_d = 1'b1;
                    ex_ctrl_d  = dec_ctrl;
                    ex_rd_d    = id_rd;
                    ex_rs1_d   = dec_rs1_used ? id_rs1 : '0;
                    ex_rs2_d   = dec_rs2_used ? id_rs2 : '0;
                    ex_ill_d   = dec_illegal;
                    md_cnt_d   = dec_ctrl[B_MULDIV] ? MD_CNT_INIT : '0;
                end else begin
                    ex_valid_d = 1'b0;
                    ex_ctrl_d  = '0;
                    ex_rd_d    = '0;
                    ex_rs1_d   = '0;
                    ex_rs2_d   = '0;
                    ex_ill_d   = 1'b0;
                    md_cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_ill_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= '0;
            md_cnt_q    <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_ill_q    <= ex_ill_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // MEM is checked first so the younger producer wins.
    always_comb begin
        mem_fwd_ok = mem_valid_q && mem_ctrl_q[B_REGWRITE] && (mem_rd_q != '0);
        wb_fwd_ok  = wb_valid_q && wb_ctrl_q[B_REGWRITE] && (wb_rd_q != '0);

        fwd_a_sel = 2'b00;
        if (mem_fwd_ok && (mem_rd_q == ex_rs1_q)) begin
            fwd_a_sel = 2'b01;
        end else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
            fwd_a_sel = 2'b10;
        end

        fwd_b_sel = 2'b00;
        if (mem_fwd_ok && (mem_rd_q == ex_rs2_q)) begin
            fwd_b_sel = 2'b01;
        end else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
            fwd_b_sel = 2'b10;
        end
    end

    assign id_ready  = id_ready_c;
    assign ex_valid  = ex_valid_q;
    assign mem_valid = mem_valid_q;
    assign wb_valid  = wb_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign ex_rd     = ex_rd_q;
    assign mem_rd    = mem_rd_q;
    assign wb_rd     = wb_rd_q;
    assign illegal   = ex_valid_q && ex_ill_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: hazards, forwarding, M-extension hold,
// redirect, external stall, illegal opcode and reset behaviour.
module tb_pipe_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_redirect;
    logic        stall_ext;

    logic        id_ready, ex_valid, mem_valid, wb_valid, illegal;
    logic [15:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    logic        nm_id_ready, nm_ex_valid, nm_mem_valid, nm_wb_valid, nm_illegal;
    logic [15:0] nm_ex_ctrl, nm_mem_ctrl, nm_wb_ctrl;
    logic [4:0]  nm_ex_rd, nm_mem_rd, nm_wb_rd;
    logic [1:0]  nm_fwd_a_sel, nm_fwd_b_sel;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_ctrl_unit #(
        .EN_MULDIV     (1),
        .MULDIV_CYCLES (8),
        .CTRL_W        (16)
    ) dut (
        .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_instr (id_instr),
        .id_ready (id_ready), .ex_redirect (ex_redirect), .stall_ext (stall_ext),
        .ex_valid (ex_valid), .mem_valid (mem_valid), .wb_valid (wb_valid),
        .ex_ctrl (ex_ctrl), .mem_ctrl (mem_ctrl), .wb_ctrl (wb_ctrl),
        .ex_rd (ex_rd), .mem_rd (mem_rd), .wb_rd (wb_rd),
        .fwd_a_sel (fwd_a_sel), .fwd_b_sel (fwd_b_sel), .illegal (illegal)
    );

    pipe_ctrl_unit #(
        .EN_MULDIV     (0),
        .MULDIV_CYCLES (8),
        .CTRL_W        (16)
    ) dut_nm (
        .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_instr (id_instr),
        .id_ready (nm_id_ready), .ex_redirect (ex_redirect), .stall_ext (stall_ext),
        .ex_valid (nm_ex_valid), .mem_valid (nm_mem_valid), .wb_valid (nm_wb_valid),
        .ex_ctrl (nm_ex_ctrl), .mem_ctrl (nm_mem_ctrl), .wb_ctrl (nm_wb_ctrl),
        .ex_rd (nm_ex_rd), .mem_rd (nm_mem_rd), .wb_rd (nm_wb_rd),
        .fwd_a_sel (nm_fwd_a_sel), .fwd_b_sel (nm_fwd_b_sel), .illegal (nm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        id_valid = 1'b0;
        repeat (3) step();
    endtask

    // Expected bundles: bit0 RegWrite, [2:1] ResultSrc, 3 MemRead, 4 MemWrite,
    // [6:5] ALUOp, 7 ALUSrc, 8 ALUASrc, 9 Branch, [11:10] Jump, 12 MulDiv.
    localparam logic [31:0] C_R     = 32'h0041;
    localparam logic [31:0] C_LOAD  = 32'h008B;
    localparam logic [31:0] C_JAL   = 32'h0407;
    localparam logic [31:0] C_MUL   = 32'h1041;

    logic [31:0] LW5, ADD6, ADD3, SUB4, ADD8, ADD9, ADD10, ADD0, ADD11, LW0, ADD12;
    logic [31:0] ADDI6, MUL7, ADD13, JAL1, ILL;
    logic [31:0] tbl_instr [6];
    logic [31:0] tbl_ctrl  [6];

    initial begin
        LW5   = i_type(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
        ADD6  = r_type(7'b0000000, 5'd1, 5'd5, 5'd6);
        ADD3  = r_type(7'b0000000, 5'd2, 5'd1, 5'd3);
        SUB4  = r_type(7'b0100000, 5'd3, 5'd3, 5'd4);
        ADD8  = r_type(7'b0000000, 5'd4, 5'd3, 5'd8);
        ADD9  = r_type(7'b0000000, 5'd2, 5'd1, 5'd9);
        ADD10 = r_type(7'b0000000, 5'd0, 5'd9, 5'd10);
        ADD0  = r_type(7'b0000000, 5'd2, 5'd1, 5'd0);
        ADD11 = r_type(7'b0000000, 5'd0, 5'd0, 5'd11);
        LW0   = i_type(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011);
        ADD12 = r_type(7'b0000000, 5'd0, 5'd0, 5'd12);
        ADDI6 = i_type(12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011);
        MUL7  = r_type(7'b0000001, 5'd2, 5'd1, 5'd7);
        ADD13 = r_type(7'b0000000, 5'd2, 5'd1, 5'd13);
        JAL1  = 32'h0080_00EF;
        ILL   = 32'h0000_007F;

        tbl_instr[0] = i_type(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);
        tbl_instr[1] = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
        tbl_instr[2] = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
        tbl_instr[3] = i_type(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111);
        tbl_instr[4] = {20'h00001, 5'd3, 7'b0110111};
        tbl_instr[5] = {20'h00001, 5'd4, 7'b0010111};
        tbl_ctrl[0] = 32'h00C1;
        tbl_ctrl[1] = 32'h0090;
        tbl_ctrl[2] = 32'h0220;
        tbl_ctrl[3] = 32'h0887;
        tbl_ctrl[4] = 32'h0085;
        tbl_ctrl[5] = 32'h0181;

        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_redirect = 1'b0; stall_ext = 1'b0;
        step();
        step();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_fwd_a", fwd_a_sel, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        settle();
        chk("rst_id_ready", id_ready, 1);
        step();

        // Decode table, back to back
        id_valid = 1'b1;
        id_instr = tbl_instr[0];
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i < 5) id_instr = tbl_instr[i + 1];
            else       id_valid = 1'b0;
            settle();
            chk("decode_ctrl", ex_ctrl, tbl_ctrl[i]);
            chk("decode_ready", id_ready, 1);
        end
        drain();

        // Load-use: LW x5 ; ADD x6,x5,x1
        id_valid = 1'b1; id_instr = LW5;
        cycle(); id_instr = ADD6; settle();
        chk("lu_ex_ctrl", ex_ctrl, C_LOAD);
        chk("lu_ex_rd", ex_rd, 5);
        chk("lu_stall", id_ready, 0);
        cycle(); settle();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl", ex_ctrl, 0);
        chk("lu_mem_rd", mem_rd, 5);
        chk("lu_resume", id_ready, 1);
        cycle(); id_valid = 1'b0; settle();
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_fwd_a", fwd_a_sel, 2);
        chk("lu_fwd_b", fwd_b_sel, 0);
        chk("lu_wb_rd", wb_rd, 5);
        drain();

        // ADD x3 ; SUB x4,x3,x3 ; ADD x8,x3,x4
        id_valid = 1'b1; id_instr = ADD3;
        cycle(); id_instr = SUB4; settle();
        chk("fw_no_stall", id_ready, 1);
        cycle(); id_instr = ADD8; settle();
        chk("fw_sub_a", fwd_a_sel, 1);
        chk("fw_sub_b", fwd_b_sel, 1);
        chk("fw_sub_rd", ex_rd, 4);
        cycle(); id_valid = 1'b0; settle();
        chk("fw_add8_a_wb", fwd_a_sel, 2);
        chk("fw_add8_b_mem", fwd_b_sel, 1);
        drain();

        // MEM beats WB when both write the same register
        id_valid = 1'b1; id_instr = ADD9;
        cycle(); cycle(); id_instr = ADD10;
        cycle(); id_valid = 1'b0; settle();
        chk("fw_mem_wins", fwd_a_sel, 1);
        chk("fw_rs2_x0", fwd_b_sel, 0);
        drain();

        // x0 is never a forwarding or hazard source
        id_valid = 1'b1; id_instr = ADD0;
        cycle(); id_instr = ADD11;
        cycle(); id_valid = 1'b0; settle();
        chk("x0_fwd_a", fwd_a_sel, 0);
        chk("x0_fwd_b", fwd_b_sel, 0);
        drain();
        id_valid = 1'b1; id_instr = LW0;
        cycle(); id_instr = ADD12; settle();
        chk("x0_no_loaduse", id_ready, 1);
        drain();

        // I-type rs2 field bits equal to the load rd must not stall
        id_valid = 1'b1; id_instr = LW5;
        cycle(); id_instr = ADDI6; settle();
        chk("itype_no_rs2_hazard", id_ready, 1);
        drain();

        // MUL hold
        id_valid = 1'b1; id_instr = MUL7;
        cycle(); id_instr = ADD13; settle();
        chk("md_ex_ctrl", ex_ctrl, C_MUL);
        chk("md_nm_ctrl", nm_ex_ctrl, C_R);
        chk("md_nm_no_hold", nm_id_ready, 1);
        for (int i = 0; i < 7; i++) begin
            chk("md_hold_ready", id_ready, 0);
            chk("md_mem_bubble", mem_valid, 0);
            step();
        end
        chk("md_final_ready", id_ready, 1);
        chk("md_final_ex", ex_ctrl, C_MUL);
        chk("md_final_bubble", mem_valid, 0);
        cycle(); id_valid = 1'b0; settle();
        chk("md_retire_ctrl", mem_ctrl, C_MUL);
        chk("md_retire_rd", mem_rd, 7);
        chk("md_next_rd", ex_rd, 13);
        drain();

        // Redirect squashes ID while the JAL advances
        id_valid = 1'b1; id_instr = JAL1;
        cycle(); id_instr = ADDI6; ex_redirect = 1'b1; settle();
        chk("rd_ex_ctrl", ex_ctrl, C_JAL);
        cycle(); ex_redirect = 1'b0; id_valid = 1'b0; settle();
        chk("rd_squash", ex_valid, 0);
        chk("rd_mem_ctrl", mem_ctrl, C_JAL);
        chk("rd_mem_valid", mem_valid, 1);
        drain();

        // stall_ext freezes a load-use stall for 3 cycles
        id_valid = 1'b1; id_instr = LW5;
        cycle(); id_instr = ADD6; stall_ext = 1'b1; settle();
        chk("st_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_ex_ctrl", ex_ctrl, C_LOAD);
            chk("st_ex_rd", ex_rd, 5);
            chk("st_mem_valid", mem_valid, 0);
            chk("st_ready_hold", id_ready, 0);
        end
        stall_ext = 1'b0; settle();
        chk("st_lu_stall", id_ready, 0);
        step();
        chk("st_bubble", ex_valid, 0);
        chk("st_mem_rd", mem_rd, 5);
        chk("st_resume", id_ready, 1);
        cycle(); id_valid = 1'b0; settle();
        chk("st_add_rd", ex_rd, 6);
        chk("st_fwd_a", fwd_a_sel, 2);
        drain();

        // Illegal opcode
        id_valid = 1'b1; id_instr = ILL;
        cycle(); id_valid = 1'b0; settle();
        chk("ill_pulse", illegal, 1);
        chk("ill_ex_valid", ex_valid, 1);
        chk("ill_ex_ctrl", ex_ctrl, 0);
        step();
        chk("ill_pulse_end", illegal, 0);
        chk("ill_mem_ctrl", mem_ctrl, 0);
        drain();

        // Reset on MulDiv cycle 4
        id_valid = 1'b1; id_instr = MUL7;
        cycle(); id_valid = 1'b0; settle();
        repeat (3) step();
        chk("mr_still_held", ex_ctrl, C_MUL);
        rst_n = 1'b0;
        step();
        chk("mr_ex_valid", ex_valid, 0);
        chk("mr_ex_ctrl", ex_ctrl, 0);
        chk("mr_ex_rd", ex_rd, 0);
        chk("mr_mem_valid", mem_valid, 0);
        chk("mr_wb_valid", wb_valid, 0);
        chk("mr_mem_ctrl", mem_ctrl, 0);
        chk("mr_illegal", illegal, 0);
        rst_n = 1'b1; settle();
        chk("mr_ready", id_ready, 1);
        step();
        chk("mr_no_retire", mem_valid, 0);
        step();
        chk("mr_no_retire_wb", wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
